sprite_blitter: RTL and testbench

//  Consumer side of the layer-descriptor interface. Steps the layer index from 0 to
//  NUM_LAYERS-1 and captures each returned descriptor: VRAM source rectangle plus FB

---
 rtl/sprite_blitter_if.sv | 36 +++
 rtl/sprite_blitter.sv | 172 +++++++++++++++++
 tb/tb_sprite_blitter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// Layer-descriptor, VRAM read and framebuffer write bus of the sprite blitter.
// The master side is the blitter; the slave side is descriptor table, VRAM and FB.
interface sprite_blitter_if #(
    parameter int PIX_W = 8,
    parameter int VA_W  = 17,
    parameter int FA_W  = 15
);
    logic             start;
    logic [32:0]      layer;
    logic [9:0]       vram_inicio_X;
    logic [9:0]       vram_inicio_Y;
    logic [9:0]       vram_final_X;
    logic [9:0]       vram_final_Y;
    logic [9:0]       FB_X;
    logic [9:0]       FB_Y;
    logic             vram_rd;
    logic [VA_W-1:0]  vram_addr;
    logic [PIX_W-1:0] vram_data;
    logic             fb_we;
    logic [FA_W-1:0]  fb_addr;
    logic [PIX_W-1:0] fb_data;
    logic             busy;
    logic             done;

    modport master (
        input  start, vram_inicio_X, vram_inicio_Y, vram_final_X, vram_final_Y,
               FB_X, FB_Y, vram_data,
        output layer, vram_rd, vram_addr, fb_we, fb_addr, fb_data, busy, done
    );

    modport slave (
        output start, vram_inicio_X, vram_inicio_Y, vram_final_X, vram_final_Y,
               FB_X, FB_Y, vram_data,
        input  layer, vram_rd, vram_addr, fb_we, fb_addr, fb_data, busy, done
    );
endinterface

// File: rtl/sprite_blitter.sv
// Walks all layer descriptors once per start pulse and copies each VRAM source
// rectangle into the framebuffer, skipping colour-keyed and off-screen pixels.
module sprite_blitter #(
    parameter int               NUM_LAYERS = 14,
    parameter int               VRAM_W     = 160,
    parameter int               FB_W       = 160,
    parameter int               FB_H       = 120,
    parameter int               PIX_W      = 8,
    parameter logic [PIX_W-1:0] TRANSP     = 8'hE3,
    parameter int               VA_W       = 17,
    parameter int               FA_W       = 15
) (
    input  logic             clk,
    input  logic             reset,
    sprite_blitter_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_RD    = 3'd2,
        S_WR    = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [32:0]     layer_q, layer_d;
    logic [9:0]      ix_q, ix_d, iy_q, iy_d, fx_q, fx_d, fy_q, fy_d;
    logic [9:0]      ox_q, ox_d, oy_q, oy_d, sx_q, sx_d, sy_q, sy_d;
    logic [VA_W-1:0] vram_addr_q, vram_addr_d;
    logic [FA_W-1:0] fb_addr_q, fb_addr_d;
    logic            clip_ok_q, clip_ok_d;

    logic            empty_s, last_pix_s, last_layer_s, in_fb_s;
    logic [10:0]     dx_s, dy_s;

    // Layer status and destination coordinates of the current source pixel
    always_comb begin
        empty_s      = (bus.vram_final_X < bus.vram_inicio_X) ||
                       (bus.vram_final_Y < bus.vram_inicio_Y);
        last_pix_s   = (sx_q == fx_q) && (sy_q == fy_q);
        last_layer_s = (layer_q == 33'(NUM_LAYERS - 1));
        // 11-bit sums so an origin near 1023 cannot wrap back onto the screen
        dx_s         = 11'(ox_q) + 11'(sx_q) - 11'(ix_q);
        dy_s         = 11'(oy_q) + 11'(sy_q) - 11'(iy_q);
        in_fb_s      = (dx_s < 11'(FB_W)) && (dy_s < 11'(FB_H));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start)   state_d = S_LATCH; else state_d = S_IDLE;
            S_LATCH: if (empty_s)     state_d = S_NEXT;  else state_d = S_RD;
            S_RD:    state_d = S_WR;
            S_WR:    if (last_pix_s)  state_d = S_NEXT;  else state_d = S_RD;
            S_NEXT:  if (last_layer_s) state_d = S_DONE; else state_d = S_LATCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Descriptor capture, raster stepping and address generation
    always_comb begin
        layer_d     = layer_q;
        ix_d        = ix_q;
        iy_d        = iy_q;
        fx_d        = fx_q;
        fy_d        = fy_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        fb_addr_d   = fb_addr_q;
        clip_ok_d   = clip_ok_q;
        vram_addr_d = vram_addr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) layer_d = 33'd0; else layer_d = layer_q;
            end
            S_LATCH: begin
                ix_d = bus.vram_inicio_X;
                iy_d = bus.vram_inicio_Y;
                fx_d = bus.vram_final_X;
                fy_d = bus.vram_final_Y;
                ox_d = bus.FB_X;
                oy_d = bus.FB_Y;
                sx_d = bus.vram_inicio_X;
                sy_d = bus.vram_inicio_Y;
            end
            S_RD: begin
                clip_ok_d = in_fb_s;
                // Clipped pixels keep the last legal address on the bus
                if (in_fb_s) fb_addr_d = FA_W'(dy_s) * FA_W'(FB_W) + FA_W'(dx_s);
                else         fb_addr_d = fb_addr_q;
            end
            S_WR: begin
                if (sx_q == fx_q) begin
                    sx_d = ix_q;
                    sy_d = sy_q + 10'd1;
                end else begin
                    sx_d = sx_q + 10'd1;
                    sy_d = sy_q;
                end
            end
            S_NEXT: begin
                if (last_layer_s) layer_d = layer_q; else layer_d = layer_q + 33'd1;
            end
            S_DONE:  layer_d = 33'd0;
            default: layer_d = layer_q;
        endcase
        if (state_d == S_RD) vram_addr_d = VA_W'(sy_d) * VA_W'(VRAM_W) + VA_W'(sx_d);
        else                 vram_addr_d = vram_addr_q;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            layer_q     <= 33'd0;
            ix_q        <= 10'd0;
            iy_q        <= 10'd0;
            fx_q        <= 10'd0;
            fy_q        <= 10'd0;
            ox_q        <= 10'd0;
            oy_q        <= 10'd0;
            sx_q        <= 10'd0;
            sy_q        <= 10'd0;
            vram_addr_q <= '0;
            fb_addr_q   <= '0;
            clip_ok_q   <= 1'b0;
        end else begin
            layer_q     <= layer_d;
            ix_q        <= ix_d;
            iy_q        <= iy_d;
            fx_q        <= fx_d;
            fy_q        <= fy_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            vram_addr_q <= vram_addr_d;
            fb_addr_q   <= fb_addr_d;
            clip_ok_q   <= clip_ok_d;
        end
    end

    // Outputs; the write strobe follows VRAM data arriving during WR
    always_comb begin
        bus.layer     = layer_q;
        bus.vram_rd   = (state_q == S_RD);
        bus.vram_addr = vram_addr_q;
        bus.fb_addr   = fb_addr_q;
        bus.busy      = (state_q != S_IDLE);
        bus.done      = (state_q == S_DONE);
        if (state_q == S_WR) begin
            bus.fb_data = bus.vram_data;
            bus.fb_we   = clip_ok_q && (bus.vram_data != TRANSP);
        end else begin
            bus.fb_data = '0;
            bus.fb_we   = 1'b0;
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed and randomized checks of sprite_blitter against a raster-loop model
// of the descriptor walk, colour key and clipping.
module tb_sprite_blitter;
    localparam int         NL = 14;
    localparam int         VW = 160;
    localparam int         FW = 160;
    localparam int         FH = 120;
    localparam logic [7:0] TR = 8'hE3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [9:0] d_ix [16];
    logic [9:0] d_iy [16];
    logic [9:0] d_fx [16];
    logic [9:0] d_fy [16];
    logic [9:0] d_ox [16];
    logic [9:0] d_oy [16];
    logic [7:0] vmem [131072];

    int exp_addr[$];
    int exp_data[$];
    int wcyc[$];
    int exp_done, exp_n, exp_rd;
    int done_cyc, n_w, n_rd, n_dual, busy_bad, idle_bad, max_addr;

    always #5 clk = ~clk;

    sprite_blitter_if bus ();

    sprite_blitter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    assign bus.vram_inicio_X = d_ix[bus.layer[3:0]];
    assign bus.vram_inicio_Y = d_iy[bus.layer[3:0]];
    assign bus.vram_final_X  = d_fx[bus.layer[3:0]];
    assign bus.vram_final_Y  = d_fy[bus.layer[3:0]];
    assign bus.FB_X          = d_ox[bus.layer[3:0]];
    assign bus.FB_Y          = d_oy[bus.layer[3:0]];

    always @(posedge clk) begin
        if (bus.vram_rd) bus.vram_data <= vmem[bus.vram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_layer(input int l, input int ix, input int iy, input int fx,
                             input int fy, input int ox, input int oy);
        d_ix[l] = 10'(ix);
        d_iy[l] = 10'(iy);
        d_fx[l] = 10'(fx);
        d_fy[l] = 10'(fy);
        d_ox[l] = 10'(ox);
        d_oy[l] = 10'(oy);
    endtask

    task automatic all_empty();
        for (int l = 0; l < 16; l++) set_layer(l, 5, 0, 3, 0, 0, 0);
    endtask

    // Reference: every layer costs 2 cycles, every source pixel 2 more
    task automatic model();
        int cyc;
        int dx, dy;
        logic [7:0] p;
        exp_addr.delete();
        exp_data.delete();
        cyc    = 0;
        exp_rd = 0;
        for (int l = 0; l < NL; l++) begin
            cyc += 2;
            if (d_fx[l] >= d_ix[l] && d_fy[l] >= d_iy[l]) begin
                for (int y = int'(d_iy[l]); y <= int'(d_fy[l]); y++) begin
                    for (int x = int'(d_ix[l]); x <= int'(d_fx[l]); x++) begin
                        cyc += 2;
                        exp_rd++;
                        dx = int'(d_ox[l]) + x - int'(d_ix[l]);
                        dy = int'(d_oy[l]) + y - int'(d_iy[l]);
                        p  = vmem[(y * VW + x) % 131072];
                        if (p != TR && dx < FW && dy < FH) begin
                            exp_addr.push_back(dy * FW + dx);
                            exp_data.push_back(int'(p));
                        end
                    end
                end
            end
        end
        exp_done = cyc + 1;
        exp_n    = exp_addr.size();
    endtask

    task automatic run_pass(input int extra_start);
        int cyc;
        int budget;
        model();
        n_w = 0; n_rd = 0; n_dual = 0; busy_bad = 0; idle_bad = 0;
        max_addr = 0; done_cyc = -1;
        wcyc.delete();
        budget = exp_done + 20;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (cyc <= budget) begin
            if (bus.vram_rd === 1'b1) n_rd++;
            if (bus.vram_rd === 1'b1 && bus.fb_we === 1'b1) n_dual++;
            if (bus.fb_we === 1'b1) begin
                n_w++;
                wcyc.push_back(cyc);
                if (int'(bus.fb_addr) > max_addr) max_addr = int'(bus.fb_addr);
                if (n_w > exp_n) begin
                    chk("write_overrun", n_w, exp_n);
                end else begin
                    chk("wr_addr", bus.fb_addr, exp_addr.pop_front());
                    chk("wr_data", bus.fb_data, exp_data.pop_front());
                end
            end
            bus.start = (cyc == extra_start);
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad++;
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) begin
            if (bus.busy !== 1'b0 || bus.vram_rd !== 1'b0 || bus.fb_we !== 1'b0) idle_bad++;
            @(negedge clk);
        end
        chk("done_cycle", done_cyc, exp_done);
        chk("write_count", n_w, exp_n);
        chk("read_count", n_rd, exp_rd);
        chk("rd_we_overlap", n_dual, 0);
        chk("busy_during_pass", busy_bad, 0);
        chk("idle_after_done", idle_bad, 0);
    endtask

    initial begin
        int found;
        int bad;
        int v;
        reset     = 1'b1;
        bus.start = 1'b0;
        all_empty();
        for (int i = 0; i < 131072; i++) vmem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_layer", bus.layer, 0);
        chk("rst_vram_rd", bus.vram_rd, 0);
        chk("rst_fb_we", bus.fb_we, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_vram_addr", bus.vram_addr, 0);
        chk("rst_fb_addr", bus.fb_addr, 0);
        chk("rst_fb_data", bus.fb_data, 0);
        reset = 1'b0;

        // single two-pixel layer
        all_empty();
        set_layer(0, 0, 0, 1, 0, 10, 5);
        vmem[0] = 8'h11;
        vmem[1] = 8'h22;
        run_pass(-1);
        chk("single_first_cycle", wcyc[0], 3);
        chk("single_second_cycle", wcyc[1], 5);

        // colour key skips only the keyed pixel
        all_empty();
        set_layer(0, 0, 0, 2, 0, 0, 0);
        vmem[0] = 8'h55;
        vmem[1] = TR;
        vmem[2] = 8'h66;
        run_pass(-1);
        chk("transp_writes", n_w, 2);

        // clipping at the bottom-right corner
        for (int y = 0; y < 34; y++) begin
            for (int x = 0; x < 40; x++) begin
                v = $urandom_range(0, 255);
                if (v == int'(TR)) v = 0;
                vmem[y * VW + x] = 8'(v);
            end
        end
        all_empty();
        set_layer(0, 0, 0, 39, 33, 140, 100);
        run_pass(-1);
        chk("clip_writes", n_w, 400);
        chk("clip_max_addr_ok", max_addr < 19200, 1);

        // every descriptor empty
        all_empty();
        run_pass(-1);
        chk("empty_done_cycle", done_cyc, 29);
        chk("empty_no_reads", n_rd, 0);

        // full pass of 1x1 layers; starts mid-pass and on DONE are ignored
        for (int l = 0; l < NL; l++) begin
            set_layer(l, l, 0, l, 0, l * 3, 7);
            vmem[l] = 8'($urandom_range(0, 200));
        end
        run_pass(20);
        chk("full_done_cycle", done_cyc, 57);
        run_pass(57);

        // reset in RD of layer 3
        for (int l = 0; l < NL; l++) set_layer(l, 0, 0, 1, 1, 2 * l, 0);
        found = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.layer === 33'd3 && bus.vram_rd === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_rd_layer3", found, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_layer", bus.layer, 0);
        chk("midrst_vram_rd", bus.vram_rd, 0);
        chk("midrst_fb_we", bus.fb_we, 0);
        reset = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.fb_we !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        chk("midrst_quiet", bad, 0);

        // randomized descriptors and VRAM contents
        for (int pass = 0; pass < 4; pass++) begin
            for (int i = 0; i < 25600; i++) begin
                if ($urandom_range(0, 5) == 0) vmem[i] = TR;
                else vmem[i] = 8'($urandom_range(0, 255));
            end
            for (int l = 0; l < NL; l++) begin
                int ix, iy, w, h;
                ix = $urandom_range(1, 150);
                iy = $urandom_range(1, 150);
                w  = $urandom_range(0, 5);
                h  = $urandom_range(0, 4);
                set_layer(l, ix, iy, ix + w - 1, iy + h - 1,
                          $urandom_range(0, 170), $urandom_range(0, 130));
            end
            run_pass(-1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
